// File: rtl/axi_lite_master_port.sv
`default_nettype none
//==============================================================================
// Module      : axi_lite_master_port
// Description : Single-outstanding request-to-AXI4-Lite master bridge.
//               Optional 16-bit saturating error counter (err_cnt_o) when
//               AXI_LITE_MASTER_ERR_CNT_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
module axi_lite_master_port #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    // request side
    input  logic                        req_i,
    input  logic                        we_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
    input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
    output logic                        gnt_o,
    output logic                        rsp_valid_o,
    output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                        rsp_err_o,
    // AXI4-Lite write address
    output logic                        aw_valid_o,
    input  logic                        aw_ready_i,
    output logic [AXI_ADDR_WIDTH-1:0]   aw_addr_o,
    output logic [2:0]                  aw_prot_o,
    // AXI4-Lite write data
    output logic                        w_valid_o,
    input  logic                        w_ready_i,
    output logic [AXI_DATA_WIDTH-1:0]   w_data_o,
    output logic [AXI_DATA_WIDTH/8-1:0] w_strb_o,
    // AXI4-Lite write response
    input  logic                        b_valid_i,
    output logic                        b_ready_o,
    input  logic [1:0]                  b_resp_i,
    // AXI4-Lite read address
    output logic                        ar_valid_o,
    input  logic                        ar_ready_i,
    output logic [AXI_ADDR_WIDTH-1:0]   ar_addr_o,
    output logic [2:0]                  ar_prot_o,
    // AXI4-Lite read data
    input  logic                        r_valid_i,
    output logic                        r_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0]   r_data_i,
    input  logic [1:0]                  r_resp_i
`ifdef AXI_LITE_MASTER_ERR_CNT_EN
    ,
    output logic [15:0]                 err_cnt_o
`endif
);

    localparam int c_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR_REQ = 3'd1,
        S_WR_RSP = 3'd2,
        S_RD_REQ = 3'd3,
        S_RD_RSP = 3'd4
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [AXI_DATA_WIDTH-1:0] r_wdata;
    logic [c_STRB_WIDTH-1:0]   r_be;
    logic                      r_aw_done;
    logic                      r_w_done;
    logic                      r_rsp_valid;
    logic                      r_rsp_err;
    logic [AXI_DATA_WIDTH-1:0] r_rsp_rdata;

    logic                      w_aw_ok;
    logic                      w_w_ok;
    logic                      w_wr_cpl;
    logic                      w_rd_cpl;

    // A channel counts as done if it handshook earlier or is handshaking now.
    assign w_aw_ok  = r_aw_done || (!r_aw_done && aw_ready_i);
    assign w_w_ok   = r_w_done  || (!r_w_done  && w_ready_i);
    assign w_wr_cpl = (r_state == S_WR_RSP) && b_valid_i;
    assign w_rd_cpl = (r_state == S_RD_RSP) && r_valid_i;

    always_comb begin
        w_state_nxt = r_state;
        gnt_o       = 1'b0;
        aw_valid_o  = 1'b0;
        w_valid_o   = 1'b0;
        b_ready_o   = 1'b0;
        ar_valid_o  = 1'b0;
        r_ready_o   = 1'b0;
        case (r_state)
            S_IDLE: begin
                gnt_o = req_i;
                if (req_i) begin
                    w_state_nxt = we_i ? S_WR_REQ : S_RD_REQ;
                end
            end
            S_WR_REQ: begin
                aw_valid_o = !r_aw_done;
                w_valid_o  = !r_w_done;
                if (w_aw_ok && w_w_ok) begin
                    w_state_nxt = S_WR_RSP;
                end
            end
            S_WR_RSP: begin
                b_ready_o = 1'b1;
                if (b_valid_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD_REQ: begin
                ar_valid_o = 1'b1;
                if (ar_ready_i) begin
                    w_state_nxt = S_RD_RSP;
                end
            end
            S_RD_RSP: begin
                r_ready_o = 1'b1;
                if (r_valid_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_valid <= 1'b0;
            if ((r_state == S_IDLE) && req_i) begin
                r_addr  <= addr_i;
                r_wdata <= wdata_i;
                r_be    <= be_i;
            end
            if (r_state == S_WR_REQ) begin
                if (w_aw_ok && w_w_ok) begin
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                end else begin
                    r_aw_done <= w_aw_ok;
                    r_w_done  <= w_w_ok;
                end
            end
            if (w_wr_cpl) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= |b_resp_i;
                r_rsp_rdata <= '0;
            end
            if (w_rd_cpl) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= |r_resp_i;
                r_rsp_rdata <= r_data_i;
            end
        end
    end

`ifdef AXI_LITE_MASTER_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    // Counts each completed response flagged as an error, one cycle after the pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err_cnt <= '0;
        end else if (r_rsp_valid && r_rsp_err && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt_o = r_err_cnt;
`endif

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_err_o   = r_rsp_err;
    assign rsp_rdata_o = r_rsp_rdata;
    assign aw_addr_o   = r_addr;
    assign ar_addr_o   = r_addr;
    assign aw_prot_o   = 3'b000;
    assign ar_prot_o   = 3'b000;
    assign w_data_o    = r_wdata;
    assign w_strb_o    = r_be;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_master_port.sv
`default_nettype none
//==============================================================================
// Module      : tb_axi_lite_master_port
// Description : Directed self-checking bench for axi_lite_master_port.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_axi_lite_master_port;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_i, we_i;
    logic [63:0] addr_i, wdata_i;
    logic [7:0]  be_i;
    logic        gnt_o, rsp_valid_o, rsp_err_o;
    logic [63:0] rsp_rdata_o;
    logic        aw_valid_o, aw_ready_i;
    logic [63:0] aw_addr_o;
    logic [2:0]  aw_prot_o;
    logic        w_valid_o, w_ready_i;
    logic [63:0] w_data_o;
    logic [7:0]  w_strb_o;
    logic        b_valid_i, b_ready_o;
    logic [1:0]  b_resp_i;
    logic        ar_valid_o, ar_ready_i;
    logic [63:0] ar_addr_o;
    logic [2:0]  ar_prot_o;
    logic        r_valid_i, r_ready_o;
    logic [63:0] r_data_i;
    logic [1:0]  r_resp_i;
`ifdef AXI_LITE_MASTER_ERR_CNT_EN
    logic [15:0] err_cnt_o;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int n_aw  = 0;
    int n_w   = 0;
    int n_ar  = 0;
    int n_rsp = 0;

    always #5 clk_i = ~clk_i;

    axi_lite_master_port dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .be_i        (be_i),
        .gnt_o       (gnt_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .aw_valid_o  (aw_valid_o),
        .aw_ready_i  (aw_ready_i),
        .aw_addr_o   (aw_addr_o),
        .aw_prot_o   (aw_prot_o),
        .w_valid_o   (w_valid_o),
        .w_ready_i   (w_ready_i),
        .w_data_o    (w_data_o),
        .w_strb_o    (w_strb_o),
        .b_valid_i   (b_valid_i),
        .b_ready_o   (b_ready_o),
        .b_resp_i    (b_resp_i),
        .ar_valid_o  (ar_valid_o),
        .ar_ready_i  (ar_ready_i),
        .ar_addr_o   (ar_addr_o),
        .ar_prot_o   (ar_prot_o),
        .r_valid_i   (r_valid_i),
        .r_ready_o   (r_ready_o),
        .r_data_i    (r_data_i),
        .r_resp_i    (r_resp_i)
`ifdef AXI_LITE_MASTER_ERR_CNT_EN
        ,
        .err_cnt_o   (err_cnt_o)
`endif
    );

    // Handshake and completion counters seen at each rising edge.
    always @(posedge clk_i) begin
        if (aw_valid_o && aw_ready_i) n_aw <= n_aw + 1;
        if (w_valid_o && w_ready_i)   n_w  <= n_w + 1;
        if (ar_valid_o && ar_ready_i) n_ar <= n_ar + 1;
        if (rsp_valid_o)              n_rsp <= n_rsp + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic request(input logic we, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [7:0] be);
        req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata; be_i = be;
    endtask

    initial begin
        rst_ni = 1'b0;
        req_i = 0; we_i = 0; addr_i = 0; wdata_i = 0; be_i = 0;
        aw_ready_i = 0; w_ready_i = 0; b_valid_i = 0; b_resp_i = 0;
        ar_ready_i = 0; r_valid_i = 0; r_data_i = 0; r_resp_i = 0;
        tick(); tick(); settle();
        check_eq("rst_ctrl", {57'd0, gnt_o, aw_valid_o, w_valid_o, b_ready_o,
                              ar_valid_o, r_ready_o, rsp_valid_o}, 64'd0);
        check_eq("rst_payload", aw_addr_o | ar_addr_o | w_data_o | {56'd0, w_strb_o}
                                | rsp_rdata_o | {63'd0, rsp_err_o}, 64'd0);
        check_eq("rst_prot", {58'd0, aw_prot_o, ar_prot_o}, 64'd0);
        rst_ni = 1'b1;
        tick();

        // Write: AW ready two cycles before W ready.
        request(1'b1, 64'h400, 64'hDEAD_BEEF, 8'hFF); settle();
        check_eq("wr1_gnt", gnt_o, 1);
        tick(); req_i = 0; settle();
        check_eq("wr1_valids", {aw_valid_o, w_valid_o}, 2'b11);
        check_eq("wr1_awaddr", aw_addr_o, 64'h400);
        check_eq("wr1_wdata", w_data_o, 64'hDEAD_BEEF);
        check_eq("wr1_wstrb", w_strb_o, 8'hFF);
        check_eq("wr1_gnt_busy", gnt_o, 0);
        aw_ready_i = 1;
        tick(); aw_ready_i = 0; settle();
        check_eq("wr1_aw_dropped", {aw_valid_o, w_valid_o}, 2'b01);
        tick(); settle();
        check_eq("wr1_w_held", {aw_valid_o, w_valid_o, b_ready_o}, 3'b010);
        w_ready_i = 1;
        tick(); w_ready_i = 0; settle();
        check_eq("wr1_wr_rsp", {aw_valid_o, w_valid_o, b_ready_o}, 3'b001);
        b_valid_i = 1; b_resp_i = 2'b00;
        tick(); b_valid_i = 0; settle();
        check_eq("wr1_rsp", {rsp_valid_o, rsp_err_o, b_ready_o}, 3'b100);
        check_eq("wr1_hs", {n_aw[7:0], n_w[7:0]}, 16'h0101);
        tick(); settle();
        check_eq("wr1_pulse_end", rsp_valid_o, 0);

        // B/R valid in IDLE must be ignored.
        b_valid_i = 1; r_valid_i = 1; r_data_i = 64'hFFFF;
        tick(); b_valid_i = 0; r_valid_i = 0; settle();
        check_eq("idle_ignore", {63'd0, rsp_valid_o} | rsp_rdata_o, 64'd0);

        // Read: AR ready after 3 cycles.
        request(1'b0, 64'hC00, 64'd0, 8'd0);
        tick(); req_i = 0; settle();
        check_eq("rd_araddr", ar_addr_o, 64'hC00);
        for (int i = 0; i < 3; i++) begin
            check_eq("rd_ar_held", {ar_valid_o, r_ready_o}, 2'b10);
            tick(); settle();
        end
        ar_ready_i = 1;
        tick(); ar_ready_i = 0; settle();
        check_eq("rd_rd_rsp", {ar_valid_o, r_ready_o}, 2'b01);
        r_valid_i = 1; r_data_i = 64'h1234; r_resp_i = 2'b00;
        tick(); r_valid_i = 0; r_data_i = 0; settle();
        check_eq("rd_rsp", {rsp_valid_o, rsp_err_o}, 2'b10);
        check_eq("rd_rdata", rsp_rdata_o, 64'h1234);
        check_eq("rd_ar_hs", n_ar, 1);
        tick(); settle();
        check_eq("rd_rdata_held", rsp_rdata_o, 64'h1234);

        // Write with AW and W ready together in the first valid cycle.
        request(1'b1, 64'h80, 64'hA5, 8'h01);
        tick(); req_i = 0; aw_ready_i = 1; w_ready_i = 1;
        tick(); aw_ready_i = 0; w_ready_i = 0; settle();
        check_eq("wr2_wr_rsp", {aw_valid_o, w_valid_o, b_ready_o}, 3'b001);
        check_eq("wr2_hs", {n_aw[7:0], n_w[7:0]}, 16'h0202);
        b_valid_i = 1;
        tick(); b_valid_i = 0; settle();
        check_eq("wr2_rsp", {rsp_valid_o, rsp_err_o}, 2'b10);
        check_eq("wr2_rdata_zero", rsp_rdata_o, 64'd0);
        check_eq("wr2_hs_once", {n_aw[7:0], n_w[7:0]}, 16'h0202);

        // Read with SLVERR.
`ifdef AXI_LITE_MASTER_ERR_CNT_EN
        check_eq("errcnt_before", err_cnt_o, 0);
`endif
        request(1'b0, 64'h100, 64'd0, 8'd0);
        tick(); req_i = 0; ar_ready_i = 1;
        tick(); ar_ready_i = 0; r_valid_i = 1; r_data_i = 64'hBAD; r_resp_i = 2'b10;
        tick(); r_valid_i = 0; r_resp_i = 0; settle();
        check_eq("rderr_rsp", {rsp_valid_o, rsp_err_o}, 2'b11);
        check_eq("rderr_rdata", rsp_rdata_o, 64'hBAD);
        tick(); settle();
        check_eq("rderr_err_held", {rsp_valid_o, rsp_err_o}, 2'b01);
`ifdef AXI_LITE_MASTER_ERR_CNT_EN
        check_eq("errcnt_after", err_cnt_o, 1);
`endif

        // Reset while waiting in WR_RSP.
        request(1'b1, 64'h200, 64'h11, 8'h03);
        tick(); req_i = 0; aw_ready_i = 1; w_ready_i = 1;
        tick(); aw_ready_i = 0; w_ready_i = 0; settle();
        check_eq("rst_mid_wr_rsp", b_ready_o, 1);
        rst_ni = 0; b_valid_i = 1; settle();
        check_eq("rst_mid_ctrl", {58'd0, gnt_o, aw_valid_o, w_valid_o, b_ready_o,
                                  rsp_valid_o, rsp_err_o}, 64'd0);
        check_eq("rst_mid_payload", aw_addr_o | w_data_o | rsp_rdata_o, 64'd0);
        begin
            int rsp_base;
            rsp_base = n_rsp;
            tick(); tick(); rst_ni = 1; b_valid_i = 0;
            tick(); tick(); settle();
            check_eq("rst_mid_no_rsp", n_rsp - rsp_base, 0);
        end
`ifdef AXI_LITE_MASTER_ERR_CNT_EN
        check_eq("rst_mid_errcnt", err_cnt_o, 0);
`endif
        request(1'b0, 64'h20, 64'd0, 8'd0);
        tick(); req_i = 0; ar_ready_i = 1;
        tick(); ar_ready_i = 0; r_valid_i = 1; r_data_i = 64'h55;
        tick(); r_valid_i = 0; settle();
        check_eq("post_rst_rd", {rsp_valid_o, rsp_err_o}, 2'b10);
        check_eq("post_rst_rdata", rsp_rdata_o, 64'h55);

        // Back-to-back: req held high across the completion.
        tick();
        request(1'b0, 64'h30, 64'd0, 8'd0);
        tick(); ar_ready_i = 1;
        tick(); ar_ready_i = 0;
        request(1'b1, 64'h40, 64'h77, 8'h0F);
        r_valid_i = 1; r_data_i = 64'h99; settle();
        check_eq("b2b_gnt_busy", gnt_o, 0);
        tick(); r_valid_i = 0; settle();
        check_eq("b2b_rsp_gnt", {rsp_valid_o, gnt_o}, 2'b11);
        check_eq("b2b_rdata", rsp_rdata_o, 64'h99);
        tick(); req_i = 0; settle();
        check_eq("b2b_wr_valids", {aw_valid_o, w_valid_o}, 2'b11);
        check_eq("b2b_wr_payload", {aw_addr_o[15:0], w_data_o[15:0], w_strb_o}, 40'h0040_0077_0F);
        aw_ready_i = 1; w_ready_i = 1;
        tick(); aw_ready_i = 0; w_ready_i = 0; b_valid_i = 1; b_resp_i = 2'b11;
        tick(); b_valid_i = 0; b_resp_i = 0; settle();
        check_eq("b2b_wr_rsp", {rsp_valid_o, rsp_err_o}, 2'b11);
        check_eq("b2b_wr_rdata", rsp_rdata_o, 64'd0);
        tick(); tick(); settle();
`ifdef AXI_LITE_MASTER_ERR_CNT_EN
        check_eq("b2b_errcnt", err_cnt_o, 1);
`endif
        check_eq("idle_end", {aw_valid_o, w_valid_o, b_ready_o, ar_valid_o, r_ready_o}, 5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
